rtc_time_reader: RTL

// - Read-back counterpart of the RTC power-up initialiser. On start, issues the clock->RAM transfer

---
 rtl/rtc_time_reader_pkg.sv | 41 ++++
 rtl/rtc_bcd_check.sv | 20 ++
 rtl/rtc_time_reader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rtc_time_reader_pkg.sv
// Shared RTC definitions: bus constants, register map, initialiser defaults and
// the read-back sequencer's state encoding.
package rtc_time_reader_pkg;

  localparam int RTC_BUS_W   = 8;
  localparam int RTC_TIMEOUT = 255;
  localparam int NUM_REGS    = 6;

  localparam logic [7:0] RTC_XFER_ADDR = 8'hF0;
  localparam logic [7:0] RTC_XFER_DATA = 8'h00;
  localparam logic [7:0] RTC_BASE_ADDR = 8'h21;

  localparam int OFS_SECONDS = 0;
  localparam int OFS_MINUTES = 1;
  localparam int OFS_HOURS   = 2;
  localparam int OFS_DATE    = 3;
  localparam int OFS_MONTH   = 4;
  localparam int OFS_YEAR    = 5;

  // Power-up time written by the initialiser, in BCD
  localparam logic [7:0] INIT_SECONDS = 8'h00;
  localparam logic [7:0] INIT_MINUTES = 8'h00;
  localparam logic [7:0] INIT_HOURS   = 8'h12;
  localparam logic [7:0] INIT_DATE    = 8'h01;
  localparam logic [7:0] INIT_MONTH   = 8'h01;
  localparam logic [7:0] INIT_YEAR    = 8'h00;

  // Inclusive BCD limits per register, ordered seconds..year
  localparam logic [7:0] REG_MIN [NUM_REGS] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
  localparam logic [7:0] REG_MAX [NUM_REGS] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_GAP,
    ST_RD,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational BCD validator: every nibble must be a decimal digit and the
// byte must lie within the inclusive [min_val, max_val] window.
module rtc_bcd_check #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] min_val,
  input  logic [W-1:0] max_val,
  output logic         valid
);

  // Ordering of packed BCD matches decimal ordering once all nibbles are digits
  always_comb begin
    valid = (value >= min_val) && (value <= max_val);
    for (int n = 0; n < W / 4; n++) begin
      if (value[n*4 +: 4] > 4'd9) valid = 1'b0;
    end
  end

endmodule

// File: rtl/rtc_time_reader.sv
// Reads the six BCD time registers from the RTC after a clock->RAM transfer
// command, validates them, and commits them atomically to the time outputs.
module rtc_time_reader
  import rtc_time_reader_pkg::*;
#(
  parameter int               BUS_W     = RTC_BUS_W,
  parameter int               TIMEOUT   = RTC_TIMEOUT,
  parameter logic [BUS_W-1:0] XFER_ADDR = RTC_XFER_ADDR,
  parameter logic [BUS_W-1:0] XFER_DATA = RTC_XFER_DATA,
  parameter logic [BUS_W-1:0] BASE_ADDR = RTC_BASE_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             bus_req,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [BUS_W-1:0] bus_rdata,
  output logic [BUS_W-1:0] seconds,
  output logic [BUS_W-1:0] minutes,
  output logic [BUS_W-1:0] hours,
  output logic [BUS_W-1:0] date,
  output logic [BUS_W-1:0] month,
  output logic [BUS_W-1:0] year
);

  localparam logic [2:0] LAST_IDX = 3'd6;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  logic [2:0]       idx;
  logic [7:0]       tmo_cnt;
  logic [BUS_W-1:0] shadow [NUM_REGS];
  logic [NUM_REGS-1:0] valid_vec;
  logic             all_valid;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_chk
    rtc_bcd_check #(.W(BUS_W)) u_chk (
      .value   (shadow[g]),
      .min_val (BUS_W'(REG_MIN[g])),
      .max_val (BUS_W'(REG_MAX[g])),
      .valid   (valid_vec[g])
    );
  end

  assign all_valid = &valid_vec;

  // Shadow bytes need no reset: they only reach the outputs after six fresh reads
  always_ff @(posedge clk) begin
    if (state == ST_RD && bus_ack) shadow[idx] <= bus_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      tmo_cnt   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      seconds   <= '0;
      minutes   <= '0;
      hours     <= '0;
      date      <= '0;
      month     <= '0;
      year      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_XFER;
            error     <= 1'b0;
            idx       <= 3'd0;
            tmo_cnt   <= 8'd0;
            busy      <= 1'b1;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= XFER_ADDR;
            bus_wdata <= XFER_DATA;
          end
        end
        ST_XFER, ST_RD: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            tmo_cnt <= 8'd0;
            if (state == ST_RD) idx <= idx + 3'd1;
            state   <= ST_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort: the engine never answered, so skip the remaining reads
            bus_req <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (idx == LAST_IDX) begin
            state <= ST_CHECK;
          end else begin
            state    <= ST_RD;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= BASE_ADDR + BUS_W'(idx);
          end
        end
        ST_CHECK: begin
          if (all_valid) begin
            seconds <= shadow[OFS_SECONDS];
            minutes <= shadow[OFS_MINUTES];
            hours   <= shadow[OFS_HOURS];
            date    <= shadow[OFS_DATE];
            month   <= shadow[OFS_MONTH];
            year    <= shadow[OFS_YEAR];
          end else begin
            error <= 1'b1;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
